// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared definitions for the 16-channel demux scan controller.
//            Holds the scan state encoding, the channel count, the last-channel
//            index and the matrix coordinate width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_CHANNELS = 16;
  localparam logic [3:0]  LAST_CHANNEL = 4'd15;
  localparam int unsigned COORD_W      = 3;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/modulo_decod_canal_mx.sv
`default_nettype none
// ============================================================================
// Module   : modulo_decod_canal_mx
// Purpose  : Combinational decode of a demux channel number into the matrix
//            column/row coordinate it addresses. The 16 channels map onto a
//            4x4 region, so the top bit of each coordinate is always zero.
// Ports    : ch  in  4        demux channel
//            mdc out COORD_W  column coordinate = {0, ch[1:0]}
//            mdl out COORD_W  row coordinate    = {0, ch[3:2]}
// Revision : 1.0 - initial release
// ============================================================================
module modulo_decod_canal_mx
  import scan_pkg::*;
(
  input  logic [3:0]         ch,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl
);

  assign mdc = {1'b0, ch[1:0]};
  assign mdl = {1'b0, ch[3:2]};

endmodule : modulo_decod_canal_mx
`default_nettype wire

// File: rtl/modulo_varredura_16_mx.sv
`default_nettype none
// ============================================================================
// Module   : modulo_varredura_16_mx
// Purpose  : Scan controller for the 1-of-16 LED matrix demux. Steps the demux
//            select through channels 0..15, DWELL cycles per channel, with an
//            optional blanking window of BLANK cycles at the start of each
//            channel, and pulses frame_done on the last cycle of channel 15.
// Macro    : SCAN_BLANK_EN - when defined the BLANK state is built in; when
//            undefined each channel spends all DWELL cycles in ON and blank
//            is only high while idle.
// Params   : DWELL (2..65535) cycles per channel
//            BLANK (1..DWELL-1) blanking cycles per channel
// Ports    : clk        in   system clock, rising edge
//            rst        in   synchronous active-high reset
//            start      in   begin a frame (sampled only in IDLE)
//            cont       in   continuous mode (sampled at end of frame)
//            dmx16_sel  out  current demux channel
//            mdc, mdl   out  column/row coordinate of the current channel
//            blank      out  matrix outputs must be disabled
//            busy       out  frame in progress
//            frame_done out  one-cycle pulse on last cycle of channel 15
// Revision : 1.0 - initial release
// ============================================================================
module modulo_varredura_16_mx
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  output logic [3:0]         dmx16_sel,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl,
  output logic               blank,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_ON   = ST_ON;

  // The counter counts down to zero; each phase loads (length - 1).
`ifdef SCAN_BLANK_EN
  localparam logic [1:0]  S_BLANK      = ST_BLANK;
  localparam logic [15:0] ON_RELOAD    = 16'(DWELL - BLANK - 1);
  localparam logic [15:0] FIRST_RELOAD = 16'(BLANK - 1);
  localparam logic [1:0]  S_CH_FIRST   = S_BLANK;
`else
  localparam logic [15:0] ON_RELOAD    = 16'(DWELL - 1);
  localparam logic [15:0] FIRST_RELOAD = ON_RELOAD;
  localparam logic [1:0]  S_CH_FIRST   = S_ON;

  // BLANK has no meaning without the blanking window.
  logic unused_blank_param;
  assign unused_blank_param = ^16'(BLANK);
`endif

  logic [1:0]         state;
  logic [1:0]         nxt_state;
  logic [3:0]         nxt_sel;
  logic [15:0]        cnt;
  logic [15:0]        nxt_cnt;
  logic [COORD_W-1:0] dec_mdc;
  logic [COORD_W-1:0] dec_mdl;

  always_comb begin
    nxt_state = state;
    nxt_sel   = dmx16_sel;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_CH_FIRST;
          nxt_sel   = 4'd0;
          nxt_cnt   = FIRST_RELOAD;
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        if (cnt == 16'd0) begin
          nxt_state = S_ON;
          nxt_cnt   = ON_RELOAD;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
`endif
      S_ON: begin
        if (cnt != 16'd0) begin
          nxt_cnt = cnt - 16'd1;
        end else if (dmx16_sel != LAST_CHANNEL || cont) begin
          // 4-bit increment wraps 15 -> 0 for continuous mode.
          nxt_state = S_CH_FIRST;
          nxt_sel   = dmx16_sel + 4'd1;
          nxt_cnt   = FIRST_RELOAD;
        end else begin
          // Select and coordinates hold the channel-15 values while idle.
          nxt_state = S_IDLE;
          nxt_cnt   = 16'd0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Decode the next channel so the coordinates register on the same edge
  // as the select.
  modulo_decod_canal_mx u_decod (
    .ch  (nxt_sel),
    .mdc (dec_mdc),
    .mdl (dec_mdl)
  );

  // All outputs are registered from next-state values, so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmx16_sel  <= 4'd0;
      mdc        <= '0;
      mdl        <= '0;
      cnt        <= 16'd0;
      blank      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      dmx16_sel  <= nxt_sel;
      mdc        <= dec_mdc;
      mdl        <= dec_mdl;
      cnt        <= nxt_cnt;
      blank      <= (nxt_state != S_ON);
      busy       <= (nxt_state != S_IDLE);
      frame_done <= (nxt_state == S_ON) && (nxt_sel == LAST_CHANNEL) &&
                    (nxt_cnt == 16'd0);
    end
  end

endmodule : modulo_varredura_16_mx
`default_nettype wire

// File: tb/tb_modulo_varredura_16_mx.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_varredura_16_mx
// Purpose  : Self-checking bench for modulo_varredura_16_mx. Instance A uses
//            DWELL=4, BLANK=1; instance B uses DWELL=2, BLANK=1. Expected
//            per-cycle output vectors are queued when a frame is started and
//            popped one per cycle while the frame runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_varredura_16_mx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, cont_a, start_b, cont_b;
  logic [3:0] sel_a, sel_b;
  logic [2:0] mdc_a, mdl_a, mdc_b, mdl_b;
  logic       blank_a, busy_a, fd_a, blank_b, busy_b, fd_b;

  int errors = 0;
  int checks = 0;

  // Vector layout: {sel[3:0], mdc[2:0], mdl[2:0], blank, busy, frame_done}
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  modulo_varredura_16_mx #(.DWELL(4), .BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont_a),
    .dmx16_sel(sel_a), .mdc(mdc_a), .mdl(mdl_a),
    .blank(blank_a), .busy(busy_a), .frame_done(fd_a)
  );

  modulo_varredura_16_mx #(.DWELL(2), .BLANK(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont_b),
    .dmx16_sel(sel_b), .mdc(mdc_b), .mdl(mdl_b),
    .blank(blank_b), .busy(busy_b), .frame_done(fd_b)
  );

  function automatic logic [12:0] pack_exp(input int ch, input logic bl,
                                           input logic bs, input logic fd);
    logic [3:0] c;
    c = ch[3:0];
    return {c, 1'b0, c[1:0], 1'b0, c[3:2], bl, bs, fd};
  endfunction

  // Blanking model for BLANK=1: only the first cycle of each channel.
  function automatic logic blank_model(input int off);
`ifdef SCAN_BLANK_EN
    return (off < 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_frame(input int d);
    for (int k = 0; k < 16 * d; k++)
      exp_q.push_back(pack_exp(k / d, blank_model(k % d), 1'b1, k == 16 * d - 1));
  endfunction

  function automatic logic [12:0] observe(input int which);
    if (which == 0) return {sel_a, mdc_a, mdl_a, blank_a, busy_a, fd_a};
    return {sel_b, mdc_b, mdl_b, blank_b, busy_b, fd_b};
  endfunction

  // Raise start before an edge; return at the sample point of frame cycle 0.
  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] a;
    // Reset held 3 cycles in the middle of a frame.
    pulse_start(0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = observe(0);
      checks++;
      if (a !== pack_exp(0, 1'b1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_frame cyc%0d: got %h required %h", i, a, pack_exp(0, 1'b1, 1'b0, 1'b0));
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    a = observe(0);
    checks++;
    if (a !== pack_exp(0, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_release_idle: got %h required %h", a, pack_exp(0, 1'b1, 1'b0, 1'b0));
    end
    // Reset landing while frame_done is high.
    pulse_start(0);
    repeat (63) @(negedge clk);
    checks++;
    if (fd_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_fd_setup: frame_done got %b required 1", fd_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a = observe(0);
    checks++;
    if (a !== pack_exp(0, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_during_fd: got %h required %h", a, pack_exp(0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_frame(input int which, input int d, input string tag);
    logic [12:0] a, e;
    cont_a = 1'b0;
    cont_b = 1'b0;
    push_frame(d);
    pulse_start(which);
    for (int i = 0; i < 16 * d; i++) begin
      a = observe(which);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 13'h1fff;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cyc%0d: got %h required %h", tag, i, a, e);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      a = observe(which);
      checks++;
      if (a !== pack_exp(15, 1'b1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL %s_idle+%0d: got %h required %h", tag, i, a, pack_exp(15, 1'b1, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    logic [12:0] a, e;
    cont_a = 1'b1;
    push_frame(4);
    push_frame(4);
    pulse_start(0);
    for (int i = 0; i < 128; i++) begin
      a = observe(0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 13'h1fff;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL continuous cyc%0d: got %h required %h", i, a, e);
      end
      if (i == 100) cont_a = 1'b0;
      @(negedge clk);
    end
    a = observe(0);
    checks++;
    if (a !== pack_exp(15, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL continuous_stop: got %h required %h", a, pack_exp(15, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    logic [12:0] a, e;
    cont_a = 1'b0;
    push_frame(4);
    pulse_start(0);
    for (int i = 0; i < 64; i++) begin
      a = observe(0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 13'h1fff;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ignored_start cyc%0d: got %h required %h", i, a, e);
      end
      start_a = (i == 10) || (i == 20);
      @(negedge clk);
    end
    start_a = 1'b0;
    a = observe(0);
    checks++;
    if (a !== pack_exp(15, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL ignored_start_end: got %h required %h", a, pack_exp(15, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [12:0] a;
    rst     = 1'b1;
    start_a = 1'b0;
    cont_a  = 1'b0;
    start_b = 1'b0;
    cont_b  = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      a = observe(w);
      checks++;
      if (a !== pack_exp(0, 1'b1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset_initial dut%0d: got %h required %h", w, a, pack_exp(0, 1'b1, 1'b0, 1'b0));
      end
    end
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_frame(0, 4, "single_frame");
    test_continuous();
    test_ignored_start();
    test_frame(1, 2, "min_dwell");

    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_modulo_varredura_16_mx
`default_nettype wire

// File: doc/modulo_varredura_16_mx.md
# modulo_varredura_16_mx

Sequential scan controller for the 1-of-16 demultiplexer that drives the LED matrix. It steps the demux select through channels 0..15 at a programmable dwell rate and decodes each channel back into the matrix column/row coordinate it addresses. It also produces a blanking strobe around every channel change and a frame-complete pulse. It sits between the frame timing logic and the demux/matrix drivers, and is the reverse direction of the coordinate-to-select path.

## Interface
- DWELL, 1000: clock cycles per channel, including blanking; legal range 2..65535.
- BLANK, 8: blanking cycles at the start of each channel; legal range 1..DWELL-1. Ignored when blanking is compiled out.
- clk  in  1  single system clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at the end of each frame.
- dmx16_sel  out  4  current demux channel, registered.
- mdc  out  3  column coordinate of the current channel, registered.
- mdl  out  3  row coordinate of the current channel, registered.
- blank  out  1  high means matrix outputs must be disabled.
- busy  out  1  high from the first frame cycle until return to IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of channel 15.

## Operation
- **States:** IDLE, BLANK, ON.
- **Reset:** state IDLE; dmx16_sel=0, mdc=0, mdl=0, blank=1, busy=0, frame_done=0; dwell counter=0.
- **IDLE**
  - blank=1, busy=0.
  - start=1 moves to BLANK on channel 0 (or to ON when blanking is compiled out).
- **BLANK**
  - blank=1, busy=1.
  - Lasts exactly BLANK cycles, then moves to ON on the same channel.
- **ON**
  - blank=0, busy=1.
  - Lasts DWELL-BLANK cycles (DWELL cycles without blanking).
  - At expiry on channels 0..14: increment the channel and move to BLANK.
  - At expiry on channel 15: assert frame_done on that last ON cycle.
    - cont=1 then wraps to channel 0 in BLANK with no idle gap.
    - cont=0 then returns to IDLE; dmx16_sel/mdc/mdl hold the channel-15 values.
- **Decode:** mdl={1'b0, ch[3:2]}, mdc={1'b0, ch[1:0]}, which covers a 4x4 region; bit 2 of both coordinates is always 0. The decode updates in the same cycle as dmx16_sel.
- **Ignored inputs:** start while busy is ignored; the frame in progress is not restarted.
- **Dwell counter:** 16-bit; reloads on every channel change; never wraps within a channel.
- **rst mid-frame:** applies the reset values on the next edge regardless of state, including during frame_done.

## Timing
- **Start:** start sampled high at edge N gives busy=1, blank=1, dmx16_sel=0 after edge N.
- **Channel period:** exactly DWELL cycles.
- **Frame length:** 16*DWELL cycles, from the first busy cycle to the cycle after frame_done.
- **Channel change:** dmx16_sel changes on the same edge that raises blank, so blank is already high in the first cycle of the new channel.
- **Continuous wrap:** channel 15 is followed directly by channel 0; consecutive frame_done pulses are 16*DWELL cycles apart.
- **End of frame with cont=0:** busy falls on the edge after frame_done.
- **Glitch-free outputs:** all outputs come straight from flops; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** SCAN_BLANK_EN.
- **Defined:** BLANK state present; behaviour as above.
- **Undefined:**
  - BLANK state and the BLANK parameter logic are removed.
  - blank=0 whenever busy=1; blank=1 in IDLE and reset.
  - Each channel spends all DWELL cycles in ON.

## Structure
- **Shared package (scan_pkg)** holds:
  - state enum (IDLE, BLANK, ON);
  - channel count constant 16;
  - last-channel constant 15;
  - coordinate width constant 3.
- **Sub-module (modulo_decod_canal_mx):** the combinational channel-to-(mdc, mdl) decode, registered by the parent. It is reusable by the verification model.

## Test plan
Benches use DWELL=4, BLANK=1 unless noted.
- **Reset:** rst held 3 cycles mid-frame, then released -> dmx16_sel=0, mdc=0, mdl=0, blank=1, busy=0, frame_done=0.
- **Single frame:** start pulse, cont=0 -> 64 busy cycles; blank high on cycles 0,4,...,60; channel 6 gives mdc=2, mdl=1; frame_done on cycle 63; busy=0 from cycle 64.
- **Continuous:** cont=1 -> channel 15 followed directly by channel 0 with blank=1; frame_done pulses 64 cycles apart.
- **Ignored start:** start pulses at cycles 10 and 20 of a frame -> no restart, frame_done still on cycle 63.
- **Blanking compiled out:** SCAN_BLANK_EN undefined -> blank=0 for all 64 busy cycles; channel changes every 4 cycles.
- **Minimum dwell:** DWELL=2, BLANK=1 -> alternating blank 1/0 every cycle; 32-cycle frame.
